// File: rtl/ram512_arbiter.sv
// ram512_arbiter: round-robin two-master sequencer in front of one 512x16 ram512.
// Define RAM512_ARB_CLEAR_EN to sweep CLEAR_VALUE through the whole memory after reset.
module ram512_arbiter #(
  parameter int                ADDR_W      = 9,
  parameter int                DATA_W      = 16,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [DATA_W-1:0] mem_in,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
);

  typedef struct packed {
    logic              own;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

`ifdef RAM512_ARB_CLEAR_EN
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, CLEAR} state_t;
  localparam state_t RST_ST = CLEAR;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam state_t RST_ST = IDLE;
`endif

  state_t            state, nxt;
  acc_t              cur_q, pick;
  logic              last_grant;
  logic              grant;
  logic [DATA_W-1:0] rdata_q;

`ifdef RAM512_ARB_CLEAR_EN
  logic [ADDR_W:0] cnt, cnt_nx;
  logic            clr_done;

  assign cnt_nx   = cnt + 1'b1;
  // The increment carries out of the address field as the last word is written.
  assign clr_done = cnt_nx[ADDR_W];

  always_ff @(posedge clk) begin
    if (reset)                cnt <= '0;
    else if (state == CLEAR)  cnt <= cnt_nx;
  end
`endif

  // Round robin: on a tie the requester that did not win last time goes next.
  always_comb begin
    pick       = '0;
    pick.own   = (req0 & req1) ? ~last_grant : req1;
    pick.we    = pick.own ? we1    : we0;
    pick.addr  = pick.own ? addr1  : addr0;
    pick.wdata = pick.own ? wdata1 : wdata0;
  end

  assign grant = (state == IDLE) & (req0 | req1);

  always_ff @(posedge clk) begin
    if (reset) state <= RST_ST;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (req0 | req1) nxt = ACCESS;
      ACCESS: nxt = DONE;
      DONE:   nxt = IDLE;
`ifdef RAM512_ARB_CLEAR_EN
      CLEAR:  if (clr_done) nxt = IDLE;
`endif
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q      <= '0;
      last_grant <= 1'b1;
      rdata_q    <= '0;
    end else begin
      if (grant) begin
        cur_q      <= pick;
        last_grant <= pick.own;
      end
      // On a write this captures the pre-write contents.
      if (state == ACCESS) rdata_q <= mem_out;
    end
  end

  // Writes are gated by reset so an abandoned ACCESS never reaches the memory.
  always_comb begin
    ack0        = 1'b0;
    ack1        = 1'b0;
    busy        = 1'b0;
    mem_address = cur_q.addr;
    mem_in      = cur_q.wdata;
    mem_load    = 1'b0;
    case (state)
      ACCESS: mem_load = cur_q.we & ~reset;
      DONE: begin
        ack0 = ~cur_q.own;
        ack1 =  cur_q.own;
      end
`ifdef RAM512_ARB_CLEAR_EN
      CLEAR: begin
        busy        = 1'b1;
        mem_address = cnt[ADDR_W-1:0];
        mem_in      = CLEAR_VALUE;
        mem_load    = ~reset;
      end
`endif
      default: ;
    endcase
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_ram512_arbiter.sv
// Scoreboard bench for ram512_arbiter with a behavioural ram512 model.
`timescale 1ns/1ps
module tb_ram512_arbiter;
  localparam int AW = 9;
  localparam int DW = 16;
`ifdef RAM512_ARB_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req   [2];
  logic          we    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          ack0, ack1, busy, mem_load;
  logic [DW-1:0] rdata, mem_in, mem_out;
  logic [AW-1:0] mem_address;

  logic [DW-1:0] mem [512];
  logic          inited = 1'b0;

  int exp0[$], exp1[$], order[$];
  string dq_nm[$];
  int dq_act[$], dq_exp[$];
  int ncmp = 0, nerr = 0, nack = 0, nload = 0, nbusy = 0;

  always #5 clk = ~clk;

  ram512_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]), .ack0(ack0),
    .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .mem_in(mem_in), .mem_address(mem_address), .mem_load(mem_load), .mem_out(mem_out)
  );

  // ram512 model: word i starts out holding i.
  always @(posedge clk) begin
    if (!inited) begin
      for (int i = 0; i < 512; i++) mem[i] <= DW'(i);
      inited <= 1'b1;
    end else if (mem_load) mem[mem_address] <= mem_in;
  end
  assign mem_out = mem[mem_address];

  function automatic int ival(input int a);
    return CLR ? 0 : a;
  endfunction

  task automatic post(input string nm, input int act, input int exp);
    dq_nm.push_back(nm); dq_act.push_back(act); dq_exp.push_back(exp);
  endtask

  task automatic score(input int id);
    int e;
    nack++;
    order.push_back(id);
    ncmp++;
    if ((id == 0 && exp0.size() == 0) || (id == 1 && exp1.size() == 0)) begin
      nerr++;
      $display("FAIL unexpected_ack%0d rdata=%0h, required no ack", id, rdata);
    end else begin
      e = (id == 0) ? exp0.pop_front() : exp1.pop_front();
      if (rdata !== DW'(e)) begin
        nerr++;
        $display("FAIL rdata_ack%0d got %0h required %0h", id, rdata, e);
      end
    end
  endtask

  // Monitor: scores every ack and drains the queued direct checks.
  always @(negedge clk) begin
    if (ack0 || ack1) begin
      ncmp++;
      if ((ack0 && ack1) || busy) begin
        nerr++;
        $display("FAIL ack_onehot ack0=%b ack1=%b busy=%b, required one ack and busy=0", ack0, ack1, busy);
      end
    end
    if (ack0) score(0);
    if (ack1) score(1);
    if (mem_load === 1'b1) nload++;
    if (busy === 1'b1) nbusy++;
    while (dq_nm.size() > 0) begin
      string nm;
      int a, e;
      nm = dq_nm.pop_front(); a = dq_act.pop_front(); e = dq_exp.pop_front();
      ncmp++;
      if (a !== e) begin
        nerr++;
        $display("FAIL %s got %0h required %0h", nm, a, e);
      end
    end
  end

  task automatic acc(input int id, input bit w, input int a, input int d,
                     input int exp_rd, input int exp_lat);
    int t;
    bit got;
    @(posedge clk); #1;
    if (id == 0) exp0.push_back(exp_rd); else exp1.push_back(exp_rd);
    req[id] = 1'b1; we[id] = w; addr[id] = AW'(a); wdata[id] = DW'(d);
    t = 0; got = 1'b0;
    while (!got && t < 2000) begin
      @(negedge clk);
      if ((id == 0) ? ack0 : ack1) got = 1'b1;
      else t++;
    end
    if (!got) post($sformatf("timeout_ack%0d", id), 0, 1);
    else if (exp_lat >= 0) post($sformatf("latency_ack%0d", id), t, exp_lat);
    @(posedge clk); #1;
    req[id] = 1'b0; we[id] = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 1000) begin @(negedge clk); t++; end
    if (busy) post("timeout_busy", 1, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    #300us;
    $display("FAIL watchdog simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int o, l0, a0;
    for (int i = 0; i < 2; i++) begin req[i] = 0; we[i] = 0; addr[i] = '0; wdata[i] = '0; end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    post("rst_ack0", int'(ack0), 0);
    post("rst_ack1", int'(ack1), 0);
    post("rst_rdata", int'(rdata), 0);
    post("rst_busy", int'(busy), int'(CLR));
    post("rst_mem_load", int'(mem_load), int'(CLR));
    wait_idle();

    // Write then read through requester 0.
    l0 = nload;
    acc(0, 1, 'h005, 'hBEEF, ival('h005), 2);
    post("wr_load_cycles", nload - l0, 1);
    l0 = nload;
    acc(0, 0, 'h005, 0, 'hBEEF, 2);
    post("rd_load_cycles", nload - l0, 0);

    // Simultaneous requests after reset: requester 0 wins the first tie.
    pulse_reset();
    wait_idle();
    o = order.size();
    fork
      acc(0, 0, 'h010, 0, ival('h010), 2);
      acc(1, 0, 'h1F0, 0, ival('h1F0), 5);
    join
    post("tie_order0", order[o], 0);
    post("tie_order1", order[o+1], 1);

    // Fairness under continuous demand.
    o = order.size();
    fork
      begin for (int k = 0; k < 3; k++) acc(0, 0, 'h020 + k, 0, ival('h020 + k), -1); end
      begin for (int k = 0; k < 3; k++) acc(1, 0, 'h030 + k, 0, ival('h030 + k), -1); end
    join
    for (int i = 0; i < 6; i++) post($sformatf("rr_order%0d", i), order[o+i], i % 2);

    // Reset asserted during the ACCESS cycle of a write.
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 9'h100; wdata[1] = 16'h1234;
    l0 = nload; a0 = nack;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    post("rst_gate_load", int'(mem_load), 0);
    @(posedge clk); #1;
    reset = 1'b0; req[1] = 1'b0; we[1] = 1'b0;
    repeat (4) @(negedge clk);
    post("rst_no_ack", nack - a0, 0);
`ifndef RAM512_ARB_CLEAR_EN
    post("rst_no_load", nload - l0, 0);
`endif
    wait_idle();
    acc(0, 0, 'h100, 0, ival('h100), 2);

    // Requester 1 writes while requester 0 queues a read of the same word.
    fork
      acc(1, 1, 'h1FF, 'h00FF, ival('h1FF), 2);
      begin @(posedge clk); acc(0, 0, 'h1FF, 0, 'h00FF, 4); end
    join

`ifdef RAM512_ARB_CLEAR_EN
    // Clear sweep holds off a request raised straight after reset.
    acc(0, 1, 'h0AA, 'hFFFF, 0, 2);
    pulse_reset();
    a0 = nbusy;
    acc(0, 0, 'h0AA, 0, 'h0000, -1);
    post("clear_busy_cycles", nbusy - a0, 512);
`endif

    repeat (3) @(negedge clk);
    post("leftover_expect", exp0.size() + exp1.size(), 0);
    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
